// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NUM_REQ requesters.
// Optional per-requester grant counters are enabled with `define ADDER_ARB_STATS_EN.
module adder_share_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  input  logic [DATA_WIDTH-1:0]         add_y,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
`ifdef ADDER_ARB_STATS_EN
  output logic [DATA_WIDTH-1:0]         rsp_sum,
  output logic [NUM_REQ*16-1:0]         grant_cnt,
  input  logic                          stats_clr
`else
  output logic [DATA_WIDTH-1:0]         rsp_sum
`endif
);

  // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // a response transfers where rsp_valid & rsp_ready. Neither valid may wait on ready.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]       grant;
  logic                  found;
  logic                  can_accept;
  logic                  accept;
  int                    idx;
  logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // The FSM state is the response-register occupancy, so rsp_valid exposes it directly.
  assign rsp_valid  = (state_q == FULL);
  assign can_accept = !rsp_valid || rsp_ready;

  // First valid requester at or after rr_ptr; defaults to rr_ptr when none is valid.
  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && can_accept && rst_n) req_ready[grant] = 1'b1;
  end

  assign accept = |req_ready;
  assign add_a  = a_arr[grant];
  assign add_b  = b_arr[grant];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      if (int'(grant) == NUM_REQ - 1) rr_ptr_d = '0;
      else                            rr_ptr_d = grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rr_ptr  <= '0;
      rsp_id  <= '0;
      rsp_sum <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr  <= rr_ptr_d;
      if (accept) begin
        rsp_id  <= grant;
        rsp_sum <= add_y;
      end
    end
  end

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  // Saturating per-requester accept counters; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr)                                     cnt_q[i] <= '0;
        else if (req_ready[i] && req_valid[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: reset, single/back-to-back grants, backpressure, wrap.
// Counter checks run only when ADDER_ARB_STATS_EN is defined.
module tb_adder_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   add_a;
  logic [DW-1:0]   add_b;
  logic [DW-1:0]   add_y;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_sum;
`ifdef ADDER_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic            stats_clr;
`endif

  int checks   = 0;
  int failures = 0;

  logic [1:0]    exp_id  [5];
  logic [DW-1:0] exp_sum [5];
  logic [N-1:0]  exp_rdy [5];

  // The shared adder lives outside the arbiter.
  assign add_y = add_a + add_b;

  adder_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef ADDER_ARB_STATS_EN
    .rsp_sum   (rsp_sum),
    .grant_cnt (grant_cnt),
    .stats_clr (stats_clr)
`else
    .rsp_sum   (rsp_sum)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
`ifdef ADDER_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    #3;
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_rsp_id",    64'(rsp_id),    64'h0);
    chk("reset_rsp_sum",   64'(rsp_sum),   64'h0);
    step();
    step();
    rst_n     = 1'b1;
    req_valid = '0;

    // 1: accept req0, then reset before the response is consumed
    set_op(0, 32'd5, 32'd7);
    req_valid = 4'b0001;
    #1;
    chk("t1_req_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    #1;
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_sum",   64'(rsp_sum),   64'hC);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("t1_post_rsp_valid", 64'(rsp_valid), 64'h0);

    // 3: all four valid, rsp_ready high -> one response per cycle in id order 0,1,2,3,0
    set_op(0, 32'h1,    32'h2);
    set_op(1, 32'h10,   32'h20);
    set_op(2, 32'h100,  32'h200);
    set_op(3, 32'h1000, 32'h2000);
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_sum = '{32'h3, 32'h30, 32'h300, 32'h3000, 32'h3};
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_req_ready", 64'(req_ready), 64'(exp_rdy[k]));
      step();
      chk("t3_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("t3_rsp_id",    64'(rsp_id),    64'(exp_id[k]));
      chk("t3_rsp_sum",   64'(rsp_sum),   64'(exp_sum[k]));
    end

    // 4: backpressure with req1 pending (rr_ptr now 1)
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_req_ready_stall", 64'(req_ready), 64'h0);
      chk("t4_rsp_valid_hold",  64'(rsp_valid), 64'h1);
      chk("t4_rsp_id_hold",     64'(rsp_id),    64'h0);
      chk("t4_rsp_sum_hold",    64'(rsp_sum),   64'h3);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_req_ready_go", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    chk("t4_rsp_id",  64'(rsp_id),  64'h1);
    chk("t4_rsp_sum", 64'(rsp_sum), 64'h30);

    // 2: single request on req2 (rr_ptr now 2)
    set_op(2, 32'h0000_0010, 32'h0000_0020);
    req_valid = 4'b0100;
    #1;
    chk("t2_req_ready", 64'(req_ready), 64'h4);
    chk("t2_add_a",     64'(add_a),     64'h10);
    chk("t2_add_b",     64'(add_b),     64'h20);
    step();
    req_valid = '0;
    #1;
    chk("t2_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t2_rsp_id",    64'(rsp_id),    64'h2);
    chk("t2_rsp_sum",   64'(rsp_sum),   64'h30);
    chk("t2_idle_add_a", 64'(add_a),    64'h1000);
    step();
    chk("t2_drain_rsp_valid", 64'(rsp_valid), 64'h0);

    // 5: carry discarded, rr_ptr=3 with req3 and req0 valid; req1 operands unknown
    set_op(3, 32'hFFFF_FFFF, 32'h2);
    set_op(0, 32'h1, 32'h1);
    req_a[1*DW +: DW] = 'x;
    req_b[1*DW +: DW] = 'x;
    req_valid = 4'b1001;
    #1;
    chk("t5_req_ready_r3", 64'(req_ready), 64'h8);
    step();
    req_valid = 4'b0001;
    #1;
    chk("t5_rsp_id_r3",    64'(rsp_id),    64'h3);
    chk("t5_rsp_sum_wrap", 64'(rsp_sum),   64'h1);
    chk("t5_req_ready_r0", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    chk("t5_rsp_id_r0",  64'(rsp_id),  64'h0);
    chk("t5_rsp_sum_r0", 64'(rsp_sum), 64'h2);
    step();
    chk("t5_drain_rsp_valid", 64'(rsp_valid), 64'h0);

`ifdef ADDER_ARB_STATS_EN
    // counts since the mid-op reset: req0 3, req1 2, req2 2, req3 2
    chk("t6_cnt0_pre", 64'(grant_cnt[15:0]),  64'd3);
    chk("t6_cnt1_pre", 64'(grant_cnt[31:16]), 64'd2);
    chk("t6_cnt2_pre", 64'(grant_cnt[47:32]), 64'd2);
    chk("t6_cnt3_pre", 64'(grant_cnt[63:48]), 64'd2);
    req_valid = 4'b0001;
    repeat (70000) step();
    chk("t6_cnt0_sat", 64'(grant_cnt[15:0]), 64'hFFFF);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("t6_clr_all", 64'(grant_cnt), 64'h0);
    req_valid = '0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
